adc_sample_framer: RTL and testbench

- Sits directly downstream of the codec ADC serial-to-parallel stage.
- Qualifies each completed 16-bit left-channel word using the codec frame clock (reclrc) and buffers it in a small FIFO.
- Delivers samples to the DSP side with a valid/ready handshake.
- Also tracks a windowed peak magnitude, used by the tone/level logic.

---
 rtl/adc_sample_framer.sv | 140 ++++++++++++++
 tb/tb_adc_sample_framer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_framer.sv
// Left-channel sample framer: captures the s2p word when the ADC frame clock falls, buffers it in
// a small FIFO for a valid/ready consumer, and tracks a windowed peak magnitude.
module adc_sample_framer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned WINDOW = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reclrc_i,
  input  logic [15:0] pin_i,
  input  logic        s_ready_i,
  output logic        s_valid_o,
  output logic [15:0] s_data_o,
  output logic        overflow_o,
  output logic [7:0]  drop_cnt_o,
  output logic [15:0] peak_o,
  output logic        peak_valid_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);
  localparam logic [15:0]   WinLast = 16'(WINDOW - 1);

  logic          reclrc_q;
  logic          cap;
  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic [15:0]   runmax_q, runmax_d;
  logic [15:0]   win_cnt_q, win_cnt_d;
  logic [15:0]   peak_q, peak_d;
  logic          peak_valid_q, peak_valid_d;

  logic          full;
  logic          rd_en;
  logic          wr_en;
  logic          drop;
  logic [15:0]   mag;
  logic [15:0]   max_mag;

  // The s2p word is complete once the frame clock has fallen.
  assign cap   = reclrc_q & ~reclrc_i;
  assign full  = (count_q == FullCnt);
  assign rd_en = s_valid_o & s_ready_i;
  assign wr_en = cap & (~full | rd_en);
  assign drop  = cap & full & ~rd_en;

  assign s_valid_o    = (count_q != '0);
  assign s_data_o     = mem_q[rd_ptr_q];
  assign overflow_o   = overflow_q;
  assign drop_cnt_o   = drop_cnt_q;
  assign peak_o       = peak_q;
  assign peak_valid_o = peak_valid_q;

  // -32768 has no positive counterpart in 16 bits, so it saturates.
  always_comb begin
    if (pin_i == 16'h8000) begin
      mag = 16'h7FFF;
    end else if (pin_i[15]) begin
      mag = 16'h0000 - pin_i;
    end else begin
      mag = pin_i;
    end
    max_mag = (mag > runmax_q) ? mag : runmax_q;
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q | drop;
    drop_cnt_d   = drop_cnt_q;
    runmax_d     = runmax_q;
    win_cnt_d    = win_cnt_q;
    peak_d       = peak_q;
    peak_valid_d = 1'b0;

    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr_en && !rd_en) begin
      count_d = count_q + CW'(1);
    end else if (!wr_en && rd_en) begin
      count_d = count_q - CW'(1);
    end

    if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;

    if (wr_en) begin
      if (win_cnt_q == WinLast) begin
        peak_d       = max_mag;
        peak_valid_d = 1'b1;
        runmax_d     = '0;
        win_cnt_d    = '0;
      end else begin
        runmax_d  = max_mag;
        win_cnt_d = win_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reclrc_q     <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= '0;
      runmax_q     <= '0;
      win_cnt_q    <= '0;
      peak_q       <= '0;
      peak_valid_q <= 1'b0;
    end else begin
      reclrc_q     <= reclrc_i;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
      runmax_q     <= runmax_d;
      win_cnt_q    <= win_cnt_d;
      peak_q       <= peak_d;
      peak_valid_q <= peak_valid_d;
    end
  end

  // Storage is cleared on reset so s_data reads zero while the FIFO is empty after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= pin_i;
    end
  end

endmodule

// File: tb/tb_adc_sample_framer.sv
// Directed testbench for adc_sample_framer with DEPTH=4, WINDOW=4; outputs sampled on negedge.
module tb_adc_sample_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reclrc = 1'b0;
  logic [15:0] pin = '0;
  logic        s_ready = 1'b0;
  logic        s_valid;
  logic [15:0] s_data;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic [15:0] peak;
  logic        peak_valid;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  adc_sample_framer #(
    .DEPTH  (4),
    .WINDOW (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .reclrc_i     (reclrc),
    .pin_i        (pin),
    .s_ready_i    (s_ready),
    .s_valid_o    (s_valid),
    .s_data_o     (s_data),
    .overflow_o   (overflow),
    .drop_cnt_o   (drop_cnt),
    .peak_o       (peak),
    .peak_valid_o (peak_valid)
  );

  // Left word shifted for 16 cycles; returns at the negedge where reclrc has just fallen.
  task automatic frame(input logic [15:0] v);
    @(negedge clk);
    reclrc = 1'b1;
    pin    = v;
    repeat (15) @(negedge clk);
    @(negedge clk);
    reclrc = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; reclrc = 1'b0; s_ready = 1'b0; pin = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL rst_s_valid got %b want 0", s_valid); end
    n_checks++; if (s_data !== 16'h0) begin n_fail++; $display("FAIL rst_s_data got %h want 0000", s_data); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow got %b want 0", overflow); end
    n_checks++; if (drop_cnt !== 8'h0) begin n_fail++; $display("FAIL rst_drop_cnt got %0d want 0", drop_cnt); end
    n_checks++; if (peak !== 16'h0) begin n_fail++; $display("FAIL rst_peak got %h want 0000", peak); end
    n_checks++; if (peak_valid !== 1'b0) begin n_fail++; $display("FAIL rst_peak_valid got %b want 0", peak_valid); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_frame();
    do_reset();
    s_ready = 1'b1;
    frame(16'h1234);
    n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass got %b want 0", s_valid); end
    @(negedge clk);
    n_checks++; if (s_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", s_valid); end
    n_checks++; if (s_data !== 16'h1234) begin n_fail++; $display("FAIL single_data got %h want 1234", s_data); end
    n_checks++; if (drop_cnt !== 8'h0) begin n_fail++; $display("FAIL single_drop got %0d want 0", drop_cnt); end
    @(negedge clk);
    n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_fall got %b want 0", s_valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 6; i++) frame(16'(i));
    @(negedge clk);
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    n_checks++; if (drop_cnt !== 8'd2) begin n_fail++; $display("FAIL ovf_drop_cnt got %0d want 2", drop_cnt); end
    s_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      n_checks++; if (s_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_rd_valid[%0d] got %b want 1", i, s_valid); end
      n_checks++; if (s_data !== 16'(i)) begin n_fail++; $display("FAIL ovf_rd_data[%0d] got %h want %h", i, s_data, 16'(i)); end
      @(negedge clk);
    end
    n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained got %b want 0", s_valid); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_still_set got %b want 1", overflow); end
  endtask

  task automatic test_full_rw();
    logic [15:0] exp_q [4];
    exp_q = '{16'h0011, 16'h0022, 16'h0033, 16'h00AA};
    do_reset();
    frame(16'h0000); frame(16'h0011); frame(16'h0022); frame(16'h0033);
    frame(16'h00AA);
    s_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL full_rw_drop got %0d want 0", drop_cnt); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_rw_ovf got %b want 0", overflow); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (s_valid !== 1'b1) begin n_fail++; $display("FAIL full_rw_valid[%0d] got %b want 1", i, s_valid); end
      n_checks++; if (s_data !== exp_q[i]) begin n_fail++; $display("FAIL full_rw_data[%0d] got %h want %h", i, s_data, exp_q[i]); end
      @(negedge clk);
    end
    n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL full_rw_drained got %b want 0", s_valid); end
  endtask

  task automatic test_peak();
    do_reset();
    s_ready = 1'b1;
    frame(16'h0010); frame(16'hFF00); frame(16'h8000);
    @(negedge clk);
    n_checks++; if (peak_valid !== 1'b0) begin n_fail++; $display("FAIL peak_early_pulse got %b want 0", peak_valid); end
    n_checks++; if (peak !== 16'h0) begin n_fail++; $display("FAIL peak_early got %h want 0000", peak); end
    frame(16'h0005);
    @(negedge clk);
    n_checks++; if (peak_valid !== 1'b1) begin n_fail++; $display("FAIL peak1_pulse got %b want 1", peak_valid); end
    n_checks++; if (peak !== 16'h7FFF) begin n_fail++; $display("FAIL peak1_value got %h want 7fff", peak); end
    @(negedge clk);
    n_checks++; if (peak_valid !== 1'b0) begin n_fail++; $display("FAIL peak1_one_cycle got %b want 0", peak_valid); end
    for (int i = 1; i <= 4; i++) frame(16'(i));
    @(negedge clk);
    n_checks++; if (peak_valid !== 1'b1) begin n_fail++; $display("FAIL peak2_pulse got %b want 1", peak_valid); end
    n_checks++; if (peak !== 16'h0004) begin n_fail++; $display("FAIL peak2_value got %h want 0004", peak); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    frame(16'h0300); frame(16'h0400);
    @(negedge clk);
    n_checks++; if (s_data !== 16'h0300) begin n_fail++; $display("FAIL mid_pre_data got %h want 0300", s_data); end
    reclrc = 1'b1; pin = 16'h0500;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %b want 0", s_valid); end
    n_checks++; if (s_data !== 16'h0) begin n_fail++; $display("FAIL mid_rst_data got %h want 0000", s_data); end
    @(negedge clk);
    reclrc = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_stale got %b want 0", s_valid); end
    s_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      frame(16'(i));
      @(negedge clk);
      n_checks++; if (s_data !== 16'(i)) begin n_fail++; $display("FAIL mid_data[%0d] got %h want %h", i, s_data, 16'(i)); end
      n_checks++; if (peak_valid !== 1'b0) begin n_fail++; $display("FAIL mid_window[%0d] got %b want 0", i, peak_valid); end
    end
    frame(16'h0004);
    @(negedge clk);
    n_checks++; if (peak_valid !== 1'b1) begin n_fail++; $display("FAIL mid_fresh_pulse got %b want 1", peak_valid); end
    n_checks++; if (peak !== 16'h0004) begin n_fail++; $display("FAIL mid_fresh_peak got %h want 0004", peak); end
  endtask

  task automatic test_drop_saturate();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      frame(16'(i));
      if (i == 99) begin
        @(negedge clk);
        n_checks++; if (drop_cnt !== 8'd96) begin n_fail++; $display("FAIL sat_mid got %0d want 96", drop_cnt); end
      end
      if (i == 258) begin
        @(negedge clk);
        n_checks++; if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_reach got %0d want 255", drop_cnt); end
      end
    end
    @(negedge clk);
    n_checks++; if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_hold got %0d want 255", drop_cnt); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL sat_ovf got %b want 1", overflow); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_overflow();
    test_full_rw();
    test_peak();
    test_reset_mid();
    test_drop_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
